// File: rtl/keypad_pkg.sv
// Shared types, key codes and seven-segment encoding for the keypad entry/display controller.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } db_state_t;

    localparam logic [3:0] KEY_BS  = 4'd10;
    localparam logic [3:0] KEY_CLR = 4'd11;

    // Segment order {g,f,e,d,c,b,a}, active high; non-decimal codes are dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises a raw one-hot keypad, debounces press and release, and emits one
// combinational valid pulse (with the key code) per accepted press.
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 20800
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_button,
    output logic [3:0]  o_code,
    output logic        o_valid
);

    localparam int             CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE - 1);

    logic [15:0]   r_sync1, r_sync2, r_snap;
    logic [CW-1:0] r_cnt;
    db_state_t     r_state;

    db_state_t     w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [15:0]   w_snap_nxt;
    logic          w_onehot;

    assign w_onehot = (r_sync2 != 16'd0) && ((r_sync2 & (r_sync2 - 16'd1)) == 16'd0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_snap  <= '0;
            r_cnt   <= '0;
            r_state <= IDLE;
        end else begin
            r_sync1 <= i_button;
            r_sync2 <= r_sync1;
            r_snap  <= w_snap_nxt;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_snap_nxt  = r_snap;
        o_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_onehot) begin
                    w_snap_nxt  = r_sync2;
                    w_cnt_nxt   = '0;
                    w_state_nxt = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (r_sync2 == r_snap) begin
                    if (r_cnt == CNT_MAX) begin
                        o_valid     = 1'b1;
                        w_state_nxt = HELD;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HELD: begin
                // Any change, including a second key joining, starts the release wait.
                if (r_sync2 != r_snap) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (r_sync2 == 16'd0) begin
                    if (r_cnt == CNT_MAX) w_state_nxt = IDLE;
                    else                  w_cnt_nxt   = r_cnt + CW'(1);
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_code = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (r_snap[k]) o_code = 4'(k);
        end
    end

endmodule

// File: rtl/keypad_display_ctrl.sv
// Keypad digit entry with BS/CLR editing and a multiplexed seven-segment scan.
// Optional: KEYPAD_LEADING_BLANK_EN blanks positions at or above the digit count.
module keypad_display_ctrl
    import keypad_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DEBOUNCE = 20800,
    parameter int SCAN_DIV = 2080
) (
    input  logic                         clk_i,
    input  logic                         reset,
    input  logic [15:0]                  button,
    output logic [6:0]                   sevenseg,
    output logic [DIGITS-1:0]            digit_en,
    output logic [4*DIGITS-1:0]          value_o,
    output logic [$clog2(DIGITS+1)-1:0]  count_o,
    output logic                         full_o,
    output logic                         key_valid_o
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]              w_code;
    logic                    w_valid;
    logic                    w_full;
    logic [DIGITS-1:0][3:0]  r_buf;
    logic [CW-1:0]           r_count;
    logic                    r_kv;
    logic [DIGITS:0][3:0]    w_up_ext, w_dn_ext;
    logic [DIGITS-1:0][3:0]  w_shift_up, w_shift_dn;
    logic [DW-1:0]           r_div;
    logic [IW-1:0]           r_scan;
    logic [DIGITS-1:0]       r_digit_en;
    logic [6:0]              r_seg, w_seg;

    key_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb (
        .i_clk    (clk_i),
        .i_reset  (reset),
        .i_button (button),
        .o_code   (w_code),
        .o_valid  (w_valid)
    );

    assign w_full     = (r_count == CNT_FULL);
    assign w_up_ext   = {r_buf, w_code};
    assign w_shift_up = w_up_ext[DIGITS-1:0];
    assign w_dn_ext   = {4'h0, r_buf};
    assign w_shift_dn = w_dn_ext[DIGITS:1];

    // Reserved codes (12-15) are debounced but never reach the buffer or key_valid_o.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_buf   <= '0;
            r_count <= '0;
            r_kv    <= 1'b0;
        end else begin
            r_kv <= 1'b0;
            if (w_valid && (w_code <= KEY_CLR)) begin
                r_kv <= 1'b1;
                if (w_code == KEY_CLR) begin
                    r_buf   <= '0;
                    r_count <= '0;
                end else if (w_code == KEY_BS) begin
                    if (r_count != '0) begin
                        r_buf   <= w_shift_dn;
                        r_count <= r_count - CW'(1);
                    end
                end else if (!w_full) begin
                    r_buf   <= w_shift_up;
                    r_count <= r_count + CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_seg = seg7(r_buf[r_scan]);
`ifdef KEYPAD_LEADING_BLANK_EN
        if ((32'(r_scan) >= 32'(r_count)) && !((r_scan == '0) && (r_count == '0)))
            w_seg = 7'h00;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_div      <= '0;
            r_scan     <= '0;
            r_digit_en <= '0;
            r_seg      <= '0;
        end else begin
            if (r_div == DIV_LAST) begin
                r_div  <= '0;
                r_scan <= (r_scan == IDX_LAST) ? '0 : r_scan + IW'(1);
            end else begin
                r_div <= r_div + DW'(1);
            end
            r_digit_en <= DIGITS'(1) << r_scan;
            r_seg      <= w_seg;
        end
    end

    assign sevenseg    = r_seg;
    assign digit_en    = r_digit_en;
    assign value_o     = r_buf;
    assign count_o     = r_count;
    assign full_o      = w_full;
    assign key_valid_o = r_kv;

endmodule
